// File: rtl/wb_defs_pkg.sv
// ============================================================================
// Module      : wb_defs_pkg
// Description : Shared widths for the register write-back path. A queued
//               entry is laid out as {reg, data}: register index in the high
//               bits, write data in the low bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_defs_pkg;
    localparam int WB_DATA_W   = 16;
    localparam int WB_ADDR_W   = 4;
    localparam int WB_NUM_REGS = 1 << WB_ADDR_W;
    localparam int WB_DEPTH    = 4;
    localparam int WB_ENTRY_W  = WB_ADDR_W + WB_DATA_W;
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : In-order FIFO of {reg, data} entries. Wrap-around index
//               pointers plus an occupancy counter. Every slot's register
//               field and valid bit are exported so the parent can build
//               a hazard mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
    parameter int DATA_W = wb_defs_pkg::WB_DATA_W,
    parameter int ADDR_W = wb_defs_pkg::WB_ADDR_W,
    parameter int DEPTH  = wb_defs_pkg::WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_reg,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_reg,
    output logic [DATA_W-1:0]        head_data,
    output logic [DEPTH*ADDR_W-1:0]  entry_regs,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               push_ok, pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_reg  = mem_q[head_q][ENTRY_W-1:DATA_W];
    assign head_data = mem_q[head_q][DATA_W-1:0];

    // A slot is live when its distance from the head is below the occupancy.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset = PTR_W'(i) - head_q;
            assign entry_valid[i] = ({1'b0, offset} < count_q);
            assign entry_regs[i*ADDR_W +: ADDR_W] = mem_q[i][ENTRY_W-1:DATA_W];
        end
    endgenerate

    // Next-state: write at tail, advance head on pop, track occupancy.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[tail_q] = {push_reg, push_data};
            tail_d        = tail_q + 1'b1;
        end
        if (pop_ok) begin
            head_d = head_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/reg_writeback_unit.sv
// ============================================================================
// Module      : reg_writeback_unit
// Description : Write-side initiator for the register bank. Arbitrates the
//               load and ALU result streams (load first), queues them in
//               order and drains one registered bank write per clock.
//               Publishes a pending-write mask for hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_writeback_unit #(
    parameter int DATA_W = wb_defs_pkg::WB_DATA_W,
    parameter int ADDR_W = wb_defs_pkg::WB_ADDR_W,
    parameter int DEPTH  = wb_defs_pkg::WB_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_W-1:0]         alu_reg,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR_W-1:0]         mem_reg,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [ADDR_W-1:0]         regC,
    output logic [DATA_W-1:0]         dado,
    output logic                      RW,
    output logic [(1<<ADDR_W)-1:0]    pend_mask,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full
);
    import wb_defs_pkg::*;

    logic                    fifo_push, fifo_empty;
    logic [ADDR_W-1:0]       push_reg, head_reg;
    logic [DATA_W-1:0]       push_data, head_data;
    logic [DEPTH*ADDR_W-1:0] entry_regs;
    logic [DEPTH-1:0]        entry_valid;

    logic [ADDR_W-1:0]       regc_q, regc_d;
    logic [DATA_W-1:0]       dado_q, dado_d;
    logic                    rw_q, rw_d;

    // Fixed-priority arbiter: a pending load always wins over the ALU.
    always_comb begin
        mem_ready = !full;
        alu_ready = !full && !mem_valid;
        fifo_push = (mem_valid || alu_valid) && !full;
        push_reg  = mem_valid ? mem_reg  : alu_reg;
        push_data = mem_valid ? mem_data : alu_data;
    end

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_reg    (push_reg),
        .push_data   (push_data),
        .pop         (!fifo_empty),
        .head_reg    (head_reg),
        .head_data   (head_data),
        .entry_regs  (entry_regs),
        .entry_valid (entry_valid),
        .count       (count),
        .full        (full),
        .empty       (fifo_empty)
    );

    // Drain stage: present the head for one cycle; hold index/data when idle.
    always_comb begin
        rw_d   = !fifo_empty;
        regc_d = fifo_empty ? regc_q : head_reg;
        dado_d = fifo_empty ? dado_q : head_data;
    end

    // Bank port registers; async reset keeps RW low while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q   <= 1'b0;
            regc_q <= '0;
            dado_q <= '0;
        end else begin
            rw_q   <= rw_d;
            regc_q <= regc_d;
            dado_q <= dado_d;
        end
    end

    assign RW   = rw_q;
    assign regC = regc_q;
    assign dado = dado_q;

    // Hazard mask: every queued destination plus the write now on the port.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_mask[entry_regs[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (rw_q) begin
            pend_mask[regc_q] = 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
// ============================================================================
// Module      : tb_reg_writeback_unit
// Description : Self-checking bench for reg_writeback_unit. A queue-based
//               reference model tracks the FIFO contents and the bank port
//               every cycle; scenario tasks add targeted checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_writeback_unit;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int NREGS  = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               alu_valid = 1'b0, mem_valid = 1'b0;
    logic               alu_ready, mem_ready;
    logic [ADDR_W-1:0]  alu_reg = '0, mem_reg = '0;
    logic [DATA_W-1:0]  alu_data = '0, mem_data = '0;
    logic [ADDR_W-1:0]  regC;
    logic [DATA_W-1:0]  dado;
    logic               RW;
    logic [NREGS-1:0]   pend_mask;
    logic [$clog2(DEPTH):0] count;
    logic               full;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t               q[$];
    logic               m_rw = 1'b0;
    logic [ADDR_W-1:0]  m_regc = '0;
    logic [DATA_W-1:0]  m_dado = '0;
    logic [DATA_W-1:0]  dut_bank [NREGS];
    logic [ADDR_W+DATA_W-1:0] wlog[$];

    reg_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .regC(regC), .dado(dado), .RW(RW), .pend_mask(pend_mask), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    // Reference model: check the current cycle, then predict the next edge.
    always @(negedge clk) begin
        logic [NREGS-1:0] exp_pend;
        logic             m_full;
        if (rst) begin
            q.delete();
            m_rw = 1'b0; m_regc = '0; m_dado = '0;
            total++;
            if (RW !== 1'b0 || count !== '0 || pend_mask !== '0 || regC !== '0 ||
                dado !== '0 || full !== 1'b0) begin
                bad++;
                $display("FAIL reset_state: RW=%b count=%0d pend=%h regC=%0d dado=%h full=%b, required all zero",
                         RW, count, pend_mask, regC, dado, full);
            end
        end else begin
            exp_pend = '0;
            foreach (q[i]) exp_pend[q[i].r] = 1'b1;
            if (m_rw) exp_pend[m_regc] = 1'b1;
            m_full = (q.size() == DEPTH);
            total++;
            if (count !== q.size() || full !== m_full || mem_ready !== !m_full ||
                alu_ready !== (!m_full && !mem_valid)) begin
                bad++;
                $display("FAIL queue_state: count=%0d full=%b mrdy=%b ardy=%b, required count=%0d full=%b mrdy=%b ardy=%b",
                         count, full, mem_ready, alu_ready, q.size(), m_full, !m_full, !m_full && !mem_valid);
            end
            total++;
            if (RW !== m_rw || (m_rw && (regC !== m_regc || dado !== m_dado))) begin
                bad++;
                $display("FAIL bank_port: RW=%b regC=%0d dado=%h, required RW=%b regC=%0d dado=%h",
                         RW, regC, dado, m_rw, m_regc, m_dado);
            end
            total++;
            if (pend_mask !== exp_pend) begin
                bad++;
                $display("FAIL pend_mask: got %h, required %h", pend_mask, exp_pend);
            end
            if (RW === 1'b1) begin
                dut_bank[regC] = dado;
                wlog.push_back({regC, dado});
            end
            // Predict the upcoming edge: pop from the pre-edge queue, then push.
            if (q.size() > 0) begin
                m_rw = 1'b1; m_regc = q[0].r; m_dado = q[0].d;
                void'(q.pop_front());
            end else begin
                m_rw = 1'b0;
            end
            if (!m_full) begin
                if (mem_valid)      q.push_back('{r: mem_reg, d: mem_data});
                else if (alu_valid) q.push_back('{r: alu_reg, d: alu_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++;
        if (RW !== 1'b0 || count !== '0 || pend_mask !== '0 || full !== 1'b0) begin
            bad++;
            $display("FAIL por_state: RW=%b count=%0d pend=%h full=%b, required 0", RW, count, pend_mask, full);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'hBEEF;
        tick();
        alu_valid = 1'b0;
        total++;
        if (pend_mask[5] !== 1'b1 || RW !== 1'b0 || count !== 1) begin
            bad++;
            $display("FAIL single_queued: pend5=%b RW=%b count=%0d, required 1 0 1", pend_mask[5], RW, count);
        end
        tick();
        total++;
        if (RW !== 1'b1 || regC !== 4'd5 || dado !== 16'hBEEF || pend_mask[5] !== 1'b1) begin
            bad++;
            $display("FAIL single_port: RW=%b regC=%0d dado=%h pend5=%b, required 1 5 beef 1",
                     RW, regC, dado, pend_mask[5]);
        end
        tick();
        total++;
        if (pend_mask[5] !== 1'b0 || RW !== 1'b0 || dut_bank[5] !== 16'hBEEF) begin
            bad++;
            $display("FAIL single_done: pend5=%b RW=%b bank5=%h, required 0 0 beef", pend_mask[5], RW, dut_bank[5]);
        end
    endtask

    task automatic test_priority();
        mem_valid = 1'b1; mem_reg = 4'd3; mem_data = 16'h1111;
        alu_valid = 1'b1; alu_reg = 4'd4; alu_data = 16'h2222;
        #1;
        total++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            bad++;
            $display("FAIL prio_ready: alu_ready=%b mem_ready=%b, required 0 1", alu_ready, mem_ready);
        end
        tick();
        mem_valid = 1'b0;
        tick();
        alu_valid = 1'b0;
        total++;
        if (RW !== 1'b1 || regC !== 4'd3 || dado !== 16'h1111) begin
            bad++;
            $display("FAIL prio_first: RW=%b regC=%0d dado=%h, required 1 3 1111", RW, regC, dado);
        end
        tick();
        total++;
        if (RW !== 1'b1 || regC !== 4'd4 || dado !== 16'h2222) begin
            bad++;
            $display("FAIL prio_second: RW=%b regC=%0d dado=%h, required 1 4 2222", RW, regC, dado);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W+DATA_W-1:0] sent[$];
        int base, peak, guard;
        base = wlog.size();
        peak = 0;
        for (int k = 1; k <= 5; k++) begin
            alu_valid = 1'b1; alu_reg = ADDR_W'(k); alu_data = DATA_W'($urandom);
            guard = 0;
            while (alu_ready !== 1'b1 && guard < 20) begin
                tick(); guard++;
            end
            sent.push_back({alu_reg, alu_data});
            tick();
            if (int'(count) > peak) peak = int'(count);
        end
        alu_valid = 1'b0;
        guard = 0;
        while ((count !== '0 || RW !== 1'b0) && guard < 20) begin
            tick(); guard++;
        end
        tick();
        // Drain pops every cycle, so a single stream never queues more than one.
        total++;
        if (peak !== 1) begin
            bad++;
            $display("FAIL b2b_peak: peak count=%0d, required 1", peak);
        end
        total++;
        if (wlog.size() - base !== 5) begin
            bad++;
            $display("FAIL b2b_count: writes=%0d, required 5", wlog.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (wlog[base+k] !== sent[k]) begin
                    bad++;
                    $display("FAIL b2b_order[%0d]: got %h, required %h", k, wlog[base+k], sent[k]);
                end
            end
        end
    endtask

    task automatic test_same_reg();
        alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'h0001;
        tick();
        alu_data = 16'h0002;
        tick();
        alu_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (pend_mask[7] !== 1'b1) begin
                bad++;
                $display("FAIL same_pend[%0d]: pend7=%b, required 1", c, pend_mask[7]);
            end
            tick();
        end
        total++;
        if (pend_mask[7] !== 1'b0 || dut_bank[7] !== 16'h0002) begin
            bad++;
            $display("FAIL same_final: pend7=%b bank7=%h, required 0 0002", pend_mask[7], dut_bank[7]);
        end
    endtask

    task automatic test_wrap_random();
        logic [ADDR_W+DATA_W-1:0] acc[$];
        int base, guard;
        logic am, aa;
        base = wlog.size();
        for (int c = 0; c < 12 * DEPTH; c++) begin
            if (!mem_valid && ($urandom_range(0, 2) == 0)) begin
                mem_valid = 1'b1; mem_reg = ADDR_W'($urandom); mem_data = DATA_W'($urandom);
            end
            if (!alu_valid && ($urandom_range(0, 1) == 0)) begin
                alu_valid = 1'b1; alu_reg = ADDR_W'($urandom); alu_data = DATA_W'($urandom);
            end
            #2;
            am = mem_valid && mem_ready;
            aa = alu_valid && alu_ready;
            if (am) acc.push_back({mem_reg, mem_data});
            else if (aa) acc.push_back({alu_reg, alu_data});
            @(posedge clk); #2;
            if (am) mem_valid = 1'b0;
            if (aa) alu_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                mem_valid = 1'b0; alu_valid = 1'b0;
                if (!am && !aa) acc = acc;
            end
        end
        // Sources may be abandoned mid-wait only when they were not accepted.
        mem_valid = 1'b0; alu_valid = 1'b0;
        guard = 0;
        while ((count !== '0 || RW !== 1'b0) && guard < 30) begin
            tick(); guard++;
        end
        total++;
        if (count !== '0 || guard >= 30) begin
            bad++;
            $display("FAIL wrap_drain: count=%0d after %0d cycles, required 0", count, guard);
        end
        total++;
        if (wlog.size() - base !== acc.size()) begin
            bad++;
            $display("FAIL wrap_total: writes=%0d, required %0d", wlog.size() - base, acc.size());
        end else begin
            foreach (acc[k]) begin
                total++;
                if (wlog[base+k] !== acc[k]) begin
                    bad++;
                    $display("FAIL wrap_data[%0d]: got %h, required %h", k, wlog[base+k], acc[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        mem_valid = 1'b1; mem_reg = 4'd9; mem_data = 16'hA5A5;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        total++;
        if (RW !== 1'b0 || count !== '0 || pend_mask !== '0) begin
            bad++;
            $display("FAIL reset_mid: RW=%b count=%0d pend=%h, required 0 0 0", RW, count, pend_mask);
        end
        mem_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        base = wlog.size();
        for (int c = 0; c < 6; c++) tick();
        total++;
        if (wlog.size() !== base || count !== '0) begin
            bad++;
            $display("FAIL reset_stale: writes=%0d count=%0d, required 0 0", wlog.size() - base, count);
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) dut_bank[i] = '0;
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_same_reg();
        test_wrap_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

`default_nettype wire
